maxpool2x2_layer: RTL and testbench

- Streaming 2x2/stride-2 max-pool stage. Sits directly downstream of conv1_layer.
- Consumes conv1_layer's 3-channel raster output (conv_out_1..3, valid_out_calc) and drives back its maxpool_ready.
- Emits one pooled pixel per 2x2 window per channel, in raster order, with a valid/ready handshake toward the next layer.

---
 rtl/maxpool_pkg.sv | 21 ++
 rtl/maxpool_row_buf.sv | 29 ++
 rtl/maxpool2x2_layer.sv | 146 ++++++++++++++
 tb/tb_maxpool2x2_layer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/maxpool_pkg.sv
// Shared types and sizing for the 2x2/stride-2 max-pool stage that follows conv1_layer.
// Pixel values are unsigned; umax is the only arithmetic the datapath needs.
package maxpool_pkg;

  localparam int DEF_IN_WIDTH  = 22;
  localparam int DEF_IN_HEIGHT = 22;
  localparam int PIX_BITS      = 23;
  localparam int DEF_NUM_CH    = 3;

  localparam int POOL_W = DEF_IN_WIDTH / 2;
  localparam int POOL_H = DEF_IN_HEIGHT / 2;

  typedef logic [PIX_BITS-1:0] pix_t;
  typedef pix_t [DEF_NUM_CH-1:0] chan_vec_t;

  // Ties may return either operand: the value is the same.
  function automatic pix_t umax(input pix_t a, input pix_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool_row_buf.sv
// Half-row buffer: one channel vector per horizontal pair of the previous even row.
// Single write port, combinational read port (small enough for distributed RAM).
module maxpool_row_buf
  import maxpool_pkg::*;
#(
  parameter int DEPTH     = POOL_W,
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int DATA_BITS = PIX_BITS,
  parameter int ADDR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                             clk,
  input  logic                             we,
  input  logic [ADDR_BITS-1:0]             waddr,
  input  logic [NUM_CH-1:0][DATA_BITS-1:0] wdata,
  input  logic [ADDR_BITS-1:0]             raddr,
  output logic [NUM_CH-1:0][DATA_BITS-1:0] rdata
);

  logic [NUM_CH-1:0][DATA_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/maxpool2x2_layer.sv
// Streaming 2x2/stride-2 max pool over three channels with valid/ready on both sides.
// Define MAXPOOL_LAST_EN to add pool_last, flagging the final pooled pixel of each frame.
module maxpool2x2_layer
  import maxpool_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int IN_HEIGHT = DEF_IN_HEIGHT,
  parameter int DATA_BITS = PIX_BITS,
  parameter int NUM_CH    = DEF_NUM_CH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] conv_in_1,
  input  logic [DATA_BITS-1:0] conv_in_2,
  input  logic [DATA_BITS-1:0] conv_in_3,
  input  logic                 valid_in,
  output logic                 maxpool_ready,
  output logic [DATA_BITS-1:0] pool_out_1,
  output logic [DATA_BITS-1:0] pool_out_2,
  output logic [DATA_BITS-1:0] pool_out_3,
  output logic                 valid_out,
  input  logic                 ready_out
`ifdef MAXPOOL_LAST_EN
  , output logic               pool_last
`endif
);

  localparam int HALF_W    = IN_WIDTH / 2;
  localparam int COL_BITS  = (IN_WIDTH > 2) ? $clog2(IN_WIDTH) : 1;
  localparam int ROW_BITS  = (IN_HEIGHT > 2) ? $clog2(IN_HEIGHT) : 1;
  localparam int ADDR_BITS = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(IN_WIDTH - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(IN_HEIGHT - 1);

  logic [NUM_CH-1:0][DATA_BITS-1:0] sample;
  logic [NUM_CH-1:0][DATA_BITS-1:0] pair_reg;
  logic [NUM_CH-1:0][DATA_BITS-1:0] pair_max;
  logic [NUM_CH-1:0][DATA_BITS-1:0] buf_rd;
  logic [NUM_CH-1:0][DATA_BITS-1:0] result;
  logic [NUM_CH-1:0][DATA_BITS-1:0] pool_reg;

  logic [COL_BITS-1:0]  col_reg;
  logic [ROW_BITS-1:0]  row_reg;
  logic [ADDR_BITS-1:0] buf_addr;
  logic                 valid_reg;
  logic                 accept;
  logic                 odd_col;
  logic                 odd_row;
  logic                 buf_we;
  logic                 load;

  assign sample[0] = conv_in_1;
  assign sample[1] = conv_in_2;
  assign sample[2] = conv_in_3;

  // Stalling the whole input while a result waits means a completing beat
  // can never arrive when the output register is still occupied.
  assign maxpool_ready = !valid_reg || ready_out;
  assign accept        = valid_in && maxpool_ready;

  assign odd_col  = col_reg[0];
  assign odd_row  = row_reg[0];
  assign buf_we   = accept && odd_col && !odd_row;
  assign load     = accept && odd_col && odd_row;
  assign buf_addr = ADDR_BITS'(col_reg >> 1);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign pair_max[gi] = umax(pair_reg[gi], sample[gi]);
    assign result[gi]   = umax(pair_max[gi], buf_rd[gi]);
  end

  maxpool_row_buf #(
    .DEPTH     (HALF_W),
    .NUM_CH    (NUM_CH),
    .DATA_BITS (DATA_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_row_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_addr),
    .wdata (pair_max),
    .raddr (buf_addr),
    .rdata (buf_rd)
  );

  // Raster position; the window phase is just the parity of row and col.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (accept) begin
      if (col_reg == COL_LAST) begin
        col_reg <= '0;
        row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pair_reg <= '0;
    end else if (accept && !odd_col) begin
      pair_reg <= sample;
    end
  end

  // A load on the same edge as a downstream accept keeps valid_out high.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      pool_reg  <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      pool_reg  <= result;
    end else if (ready_out) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid_out  = valid_reg;
  assign pool_out_1 = pool_reg[0];
  assign pool_out_2 = pool_reg[1];
  assign pool_out_3 = pool_reg[2];

`ifdef MAXPOOL_LAST_EN
  logic last_reg;
  logic frame_end;

  assign frame_end = (row_reg == ROW_LAST) && (col_reg == COL_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg <= 1'b0;
    end else if (load) begin
      last_reg <= frame_end;
    end else if (ready_out) begin
      last_reg <= 1'b0;
    end
  end

  assign pool_last = last_reg;
`endif

endmodule

// File: tb/tb_maxpool2x2_layer.sv
// Directed bench for maxpool2x2_layer: ramp, back-to-back frames, backpressure,
// gapped input, max position in window (0,0), and reset mid-frame.
module tb_maxpool2x2_layer;

  localparam int W      = 22;
  localparam int H      = 22;
  localparam int DB     = 23;
  localparam int NB     = W * H;
  localparam int NO     = (W / 2) * (H / 2);
  localparam int BUDGET = 5000;
  localparam logic [DB-1:0] PMAX = 23'h7FFFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic [DB-1:0] conv_in_1, conv_in_2, conv_in_3;
  logic          valid_in;
  logic          maxpool_ready;
  logic [DB-1:0] pool_out_1, pool_out_2, pool_out_3;
  logic          valid_out;
  logic          ready_out;
`ifdef MAXPOOL_LAST_EN
  logic          pool_last;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  maxpool2x2_layer dut (
    .clk           (clk),
    .rst           (rst),
    .conv_in_1     (conv_in_1),
    .conv_in_2     (conv_in_2),
    .conv_in_3     (conv_in_3),
    .valid_in      (valid_in),
    .maxpool_ready (maxpool_ready),
    .pool_out_1    (pool_out_1),
    .pool_out_2    (pool_out_2),
    .pool_out_3    (pool_out_3),
    .valid_out     (valid_out),
    .ready_out     (ready_out)
`ifdef MAXPOOL_LAST_EN
    , .pool_last   (pool_last)
`endif
  );

  // mode 0/1/2: ramp (ch1=i, ch2=i+1, ch3=1000-i); mode 3: zeros with PMAX at pos
  function automatic logic [DB-1:0] in_val(input int mode, input int ch, input int i, input int pos);
    if (i >= NB) return '0;
    if (mode == 3) return (i == pos) ? PMAX : '0;
    case (ch)
      0:       return DB'(i);
      1:       return DB'(i + 1);
      default: return DB'(1000 - i);
    endcase
  endfunction

  // Window n covers beats lo, lo+1, lo+W, lo+W+1; ramp max is at the last (or first for ch3).
  function automatic logic [DB-1:0] exp_val(input int mode, input int ch, input int n);
    int r  = n / (W / 2);
    int c  = n % (W / 2);
    int lo = 2 * r * W + 2 * c;
    int hi = lo + W + 1;
    if (mode == 3) return (n == 0) ? PMAX : '0;
    case (ch)
      0:       return DB'(hi);
      1:       return DB'(hi + 1);
      default: return DB'(1000 - lo);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int mode, input int i, input int pos);
    conv_in_1 = in_val(mode, 0, i, pos);
    conv_in_2 = in_val(mode, 1, i, pos);
    conv_in_3 = in_val(mode, 2, i, pos);
  endtask

  task automatic run_frame(input int mode, input int pos);
    int i = 0;
    int n = 0;
    int cyc = 0;
    int stall_left = 0;
    bit stalled_once = 1'b0;
    bit prev_done = 1'b0;
    while ((i < NB || n < NO) && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (mode == 1 && valid_out && !stalled_once) begin
        stalled_once = 1'b1;
        stall_left = 10;
      end
      if (stall_left > 0) begin
        ready_out = 1'b0;
        stall_left--;
      end else begin
        ready_out = 1'b1;
      end
      valid_in = (i < NB) && !(mode == 2 && (cyc % 2) == 0);
      drive(mode, i, pos);
      #1;
      if (mode != 1) check("valid_out_timing", valid_out, prev_done);
      if (!ready_out) begin
        check("stall_ready", maxpool_ready, 1'b0);
        check("stall_valid", valid_out, 1'b1);
        check("stall_hold", pool_out_1, exp_val(mode, 0, 0));
      end
      if (valid_out && ready_out) begin
        if (n < NO) begin
          $display("[TB] mode=%0d pos=%0d out=%0d ch=%0d,%0d,%0d", mode, pos, n,
                   pool_out_1, pool_out_2, pool_out_3);
          check("pool_out_1", pool_out_1, exp_val(mode, 0, n));
          check("pool_out_2", pool_out_2, exp_val(mode, 1, n));
          check("pool_out_3", pool_out_3, exp_val(mode, 2, n));
`ifdef MAXPOOL_LAST_EN
          check("pool_last", pool_last, (n == NO - 1));
`endif
        end
        n++;
      end
      prev_done = 1'b0;
      if (valid_in && maxpool_ready) begin
        prev_done = ((i / W) % 2 == 1) && ((i % W) % 2 == 1);
        i++;
      end
    end
    check("beats_accepted", i, NB);
    check("outputs_seen", n, NO);
    valid_in = 1'b0;
    ready_out = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("idle_valid", valid_out, 1'b0);
  endtask

  initial begin
    int k;
    int guard;
    int positions[4] = '{0, 1, W, W + 1};
    rst = 1'b1;
    valid_in = 1'b0;
    ready_out = 1'b1;
    drive(0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_valid", valid_out, 1'b0);
    check("reset_ready", maxpool_ready, 1'b1);
    check("reset_out_1", pool_out_1, '0);
    check("reset_out_3", pool_out_3, '0);

    run_frame(0, 0);
    run_frame(0, 0);
    run_frame(1, 0);
    run_frame(2, 0);
    for (int p = 0; p < 4; p++) run_frame(3, positions[p]);

    k = 0;
    guard = 0;
    while (k < 100 && guard < 1000) begin
      @(negedge clk);
      guard++;
      ready_out = 1'b1;
      valid_in = 1'b1;
      drive(0, k, 0);
      #1;
      if (maxpool_ready) k++;
    end
    check("partial_beats", k, 100);
    @(negedge clk);
    valid_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset_valid", valid_out, 1'b0);
    check("midreset_ready", maxpool_ready, 1'b1);
    check("midreset_out_1", pool_out_1, '0);
    run_frame(0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
